// File: rtl/encoder8x3_seq.sv
// encoder8x3_seq: sequential 8-to-3 encoder.
// An accepted request vector is held in a pending register. Each set bit is
// emitted as a 3-bit index {a,b,c}, one per handshake, in scan order, until
// the vector is used up. LOW_FIRST selects whether bit 0 or bit 7 comes first.
// Every output is a flop, so nothing reaches the outputs combinationally from
// in_* or out_ready.
module encoder8x3_seq #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_vec,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       err_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] pending;
    logic [7:0] remaining;

    // Index of the first set bit in scan order. Returns 0 for an empty vector.
    function automatic logic [2:0] scan_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (LOW_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic is_single(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Pending bits left once the index now on {a,b,c} has been consumed.
    always_comb begin
        remaining = pending & ~(8'd1 << {a, b, c});
    end

    // Control FSM. It also loads the registered index, last flag and handshake
    // outputs, so each output already holds its final value for the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 8'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err_zero  <= 1'b0;
            {a, b, c} <= 3'd0;
        end else begin
            err_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_vec == 8'd0) begin
                            err_zero <= 1'b1;
                        end else begin
                            state     <= EMIT;
                            pending   <= in_vec;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_last  <= is_single(in_vec);
                            {a, b, c} <= scan_index(in_vec);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            pending   <= 8'd0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            {a, b, c} <= 3'd0;
                        end else begin
                            pending   <= remaining;
                            out_last  <= is_single(remaining);
                            {a, b, c} <= scan_index(remaining);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    pending   <= 8'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    {a, b, c} <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder8x3_seq.sv
// Testbench for encoder8x3_seq. Two instances share one set of inputs:
// lo scans from bit 0 upward, hi scans from bit 7 downward.
// A queue-based reference model runs alongside them. It expands each accepted
// vector into its list of indices and pops one index per output handshake.
module tb_encoder8x3_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready_lo, a_lo, b_lo, c_lo, out_valid_lo, out_last_lo, err_zero_lo;
    logic       in_ready_hi, a_hi, b_hi, c_hi, out_valid_hi, out_last_hi, err_zero_hi;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    int q_low[$];
    int q_high[$];
    bit err_exp;

    encoder8x3_seq #(.LOW_FIRST(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_lo),
        .in_vec(in_vec), .a(a_lo), .b(b_lo), .c(c_lo), .out_valid(out_valid_lo),
        .out_ready(out_ready), .out_last(out_last_lo), .err_zero(err_zero_lo)
    );

    encoder8x3_seq #(.LOW_FIRST(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_hi),
        .in_vec(in_vec), .a(a_hi), .b(b_hi), .c(c_hi), .out_valid(out_valid_hi),
        .out_ready(out_ready), .out_last(out_last_hi), .err_zero(err_zero_hi)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 3x8 decoder used to map an encoded index back to a vector.
    function automatic logic [7:0] decoder3x8(input logic [2:0] idx);
        logic [7:0] one;
        one = 8'd1;
        return one << idx;
    endfunction

    // Compares one value against its expectation and records the result.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model. Each accepted nonzero vector becomes two index lists,
    // one per scan order. While the lists hold entries the block is busy, and
    // each out_ready edge removes the front entry.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_low.delete();
            q_high.delete();
            err_exp = 1'b0;
        end else begin
            err_exp = 1'b0;
            if (q_low.size() != 0) begin
                if (out_ready) begin
                    void'(q_low.pop_front());
                    void'(q_high.pop_front());
                end
            end else if (in_valid) begin
                if (in_vec == 8'd0) begin
                    err_exp = 1'b1;
                end else begin
                    for (int i = 0; i < 8; i++) if (in_vec[i]) q_low.push_back(i);
                    for (int i = 7; i >= 0; i--) if (in_vec[i]) q_high.push_back(i);
                end
            end
        end
    end

    // Every cycle, compares both instances against the model on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("lo_valid", out_valid_lo, q_low.size() != 0);
            checkOutput("lo_ready", in_ready_lo, q_low.size() == 0);
            checkOutput("lo_abc", {a_lo, b_lo, c_lo}, (q_low.size() != 0) ? q_low[0] : 0);
            checkOutput("lo_last", out_last_lo, q_low.size() == 1);
            checkOutput("lo_err", err_zero_lo, err_exp);
            checkOutput("hi_valid", out_valid_hi, q_high.size() != 0);
            checkOutput("hi_ready", in_ready_hi, q_high.size() == 0);
            checkOutput("hi_abc", {a_hi, b_hi, c_hi}, (q_high.size() != 0) ? q_high[0] : 0);
            checkOutput("hi_last", out_last_hi, q_high.size() == 1);
            checkOutput("hi_err", err_zero_hi, err_exp);
        end
    end

    // Advances to just after the next falling edge, the point where inputs are driven.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Presents one vector for a single cycle, for an instance that is idle.
    task automatic applyStimulus(input logic [7:0] vec);
        in_valid = 1'b1;
        in_vec   = vec;
        tick();
        in_valid = 1'b0;
        in_vec   = 8'd0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'd0;
        out_ready = 1'b0;
        tick();
        // Outputs while reset is held.
        checkOutput("rst_valid", out_valid_lo, 0);
        checkOutput("rst_ready", in_ready_lo, 1);
        checkOutput("rst_abc", {a_hi, b_hi, c_hi}, 0);
        checkOutput("rst_err", err_zero_lo, 0);
        rst_n = 1'b1;
        check_en = 1'b1;
        tick();

        // Single bit 2: one index, marked last, then back to idle.
        out_ready = 1'b1;
        applyStimulus(8'b0000_0100);
        checkOutput("d1_valid", out_valid_lo, 1);
        checkOutput("d1_abc", {a_lo, b_lo, c_lo}, 3'b010);
        checkOutput("d1_last", out_last_lo, 1);
        checkOutput("d1_ready", in_ready_lo, 0);
        tick();
        checkOutput("d1_idle_ready", in_ready_lo, 1);
        checkOutput("d1_idle_valid", out_valid_lo, 0);

        // Bits 0 and 7: two back-to-back indices in each scan order.
        applyStimulus(8'b1000_0001);
        checkOutput("d2_lo_first", {a_lo, b_lo, c_lo}, 0);
        checkOutput("d2_lo_first_last", out_last_lo, 0);
        checkOutput("d2_hi_first", {a_hi, b_hi, c_hi}, 7);
        tick();
        checkOutput("d2_lo_second", {a_lo, b_lo, c_lo}, 7);
        checkOutput("d2_lo_second_last", out_last_lo, 1);
        checkOutput("d2_hi_second", {a_hi, b_hi, c_hi}, 0);
        tick();

        // All ones with out_ready low for three cycles: the first index holds.
        out_ready = 1'b0;
        applyStimulus(8'hFF);
        for (int k = 0; k < 3; k++) begin
            checkOutput("d3_hold_lo", {a_lo, b_lo, c_lo}, 0);
            checkOutput("d3_hold_hi", {a_hi, b_hi, c_hi}, 7);
            checkOutput("d3_hold_last", out_last_lo, 0);
            if (k < 2) tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("d3_seq_lo", {a_lo, b_lo, c_lo}, i);
            checkOutput("d3_seq_hi", {a_hi, b_hi, c_hi}, 7 - i);
            checkOutput("d3_seq_last", out_last_lo, i == 7);
            tick();
        end
        checkOutput("d3_end_ready", in_ready_lo, 1);

        // An all-zero vector raises err_zero for exactly one cycle.
        applyStimulus(8'h00);
        checkOutput("d4_err", err_zero_lo, 1);
        checkOutput("d4_valid", out_valid_lo, 0);
        checkOutput("d4_ready", in_ready_lo, 1);
        tick();
        checkOutput("d4_err_gone", err_zero_lo, 0);
        checkOutput("d4_valid2", out_valid_lo, 0);

        // Reset in the middle of a vector, once three indices have been emitted.
        applyStimulus(8'hFF);
        tick();
        tick();
        tick();
        checkOutput("d5_before_rst", {a_lo, b_lo, c_lo}, 3);
        rst_n = 1'b0;
        #1;
        checkOutput("d5_rst_valid", out_valid_lo, 0);
        checkOutput("d5_rst_ready", in_ready_lo, 1);
        checkOutput("d5_rst_abc", {a_lo, b_lo, c_lo}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("d5_after_valid", out_valid_lo, 0);
        checkOutput("d5_after_ready", in_ready_lo, 1);
        // The first edge after reset release accepts a new vector.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(8'h10);
        checkOutput("d5_first_accept", {a_lo, b_lo, c_lo}, 4);
        checkOutput("d5_first_valid", out_valid_lo, 1);
        tick();

        // Each one-hot vector, encoded and then decoded, gives back the same vector.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] onehot;
            onehot = decoder3x8(3'(i));
            applyStimulus(onehot);
            checkOutput("d6_decode_lo", decoder3x8({a_lo, b_lo, c_lo}), onehot);
            checkOutput("d6_decode_hi", decoder3x8({a_hi, b_hi, c_hi}), onehot);
            tick();
        end

        // Random traffic, including occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0: in_vec = 8'd0;
                1: in_vec = decoder3x8(3'($urandom_range(0, 7)));
                default: in_vec = 8'($urandom);
            endcase
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) tick();

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
